// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle for the sequential ALU.
//   master : drives start, op, x, y; observes busy, done, f, f_hi, cout, overflow
//   slave  : the ALU side of the same signals
interface seq_alu_if #(
  parameter int W = 8
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] f;
  logic [W-1:0] f_hi;
  logic         cout;
  logic         overflow;

  modport master (
    output start, op, x, y,
    input  busy, done, f, f_hi, cout, overflow
  );

  modport slave (
    input  start, op, x, y,
    output busy, done, f, f_hi, cout, overflow
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: two-state sequential ALU (MUL / CMP / ADD / SUB).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_alu_if slave port
//           start/op/x/y in; busy, done (1-cycle pulse), f, f_hi, cout, overflow out
// CMP/ADD/SUB complete one edge after acceptance; MUL is an unsigned
// shift-add taking W edges, one multiplier bit per edge, LSB first.
module seq_alu #(
  parameter int W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Two's complement overflow of a + b given the sign bits of a, b and the sum.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_t         state_r;
  state_t         state_nx_s;
  logic           finish_s;
  logic           accept_s;

  logic [1:0]     op_r;
  logic [W-1:0]   a_r;       // multiplicand / operand A
  logic [W-1:0]   b_r;       // operand B; doubles as the multiplier/low-product shift register
  logic [W-1:0]   hi_r;      // MUL partial-product high half
  logic [CW-1:0]  cnt_r;

  logic [W-1:0]   f_r;
  logic [W-1:0]   f_hi_r;
  logic           cout_r;
  logic           ovf_r;
  logic           done_r;

  logic [W:0]     mul_add_s;
  logic [W-1:0]   step_hi_s;
  logic [W-1:0]   step_lo_s;
  logic [W:0]     sum_s;
  logic [W-1:0]   res_f_s;
  logic [W-1:0]   res_hi_s;
  logic           res_c_s;
  logic           res_v_s;

  assign accept_s = (state_r == IDLE) && bus.start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and completion decode; start is only looked at in IDLE.
  always_comb begin
    state_nx_s = state_r;
    finish_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nx_s = EXEC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      EXEC: begin
        if ((op_r != OP_MUL) || (cnt_r == CNT_LAST)) begin
          finish_s   = 1'b1;
          state_nx_s = IDLE;
        end else begin
          state_nx_s = EXEC;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // One shift-add step: add multiplicand when the current multiplier bit is
  // set, then shift {carry, hi, lo} right so the product builds up in {hi, lo}.
  always_comb begin
    mul_add_s = {1'b0, hi_r} + {1'b0, (b_r[0] ? a_r : {W{1'b0}})};
    step_hi_s = mul_add_s[W:1];
    step_lo_s = {mul_add_s[0], b_r[W-1:1]};
  end

  // Result selection; SUB is x + ~y + 1 so cout=1 means no borrow.
  always_comb begin
    sum_s    = {1'b0, a_r} + {1'b0, ((op_r == OP_SUB) ? ~b_r : b_r)} + {{W{1'b0}}, (op_r == OP_SUB)};
    res_f_s  = {W{1'b0}};
    res_hi_s = {W{1'b0}};
    res_c_s  = 1'b0;
    res_v_s  = 1'b0;
    case (op_r)
      OP_MUL: begin
        res_f_s  = step_lo_s;
        res_hi_s = step_hi_s;
        res_v_s  = |step_hi_s;
      end
      OP_CMP: begin
        res_c_s  = (a_r > b_r);
      end
      OP_ADD: begin
        res_f_s  = sum_s[W-1:0];
        res_c_s  = sum_s[W];
        res_v_s  = add_ovf(a_r[W-1], b_r[W-1], sum_s[W-1]);
      end
      OP_SUB: begin
        res_f_s  = sum_s[W-1:0];
        res_c_s  = sum_s[W];
        res_v_s  = add_ovf(a_r[W-1], ~b_r[W-1], sum_s[W-1]);
      end
      default: begin
        res_f_s  = {W{1'b0}};
      end
    endcase
  end

  // Operand latch, MUL iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= 2'b00;
      a_r    <= {W{1'b0}};
      b_r    <= {W{1'b0}};
      hi_r   <= {W{1'b0}};
      cnt_r  <= {CW{1'b0}};
      f_r    <= {W{1'b0}};
      f_hi_r <= {W{1'b0}};
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= finish_s;
      if (accept_s) begin
        op_r  <= bus.op;
        a_r   <= bus.x;
        b_r   <= bus.y;
        hi_r  <= {W{1'b0}};
        cnt_r <= {CW{1'b0}};
      end else if (state_r == EXEC) begin
        if (op_r == OP_MUL) begin
          hi_r  <= step_hi_s;
          b_r   <= step_lo_s;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        if (finish_s) begin
          f_r    <= res_f_s;
          f_hi_r <= res_hi_s;
          cout_r <= res_c_s;
          ovf_r  <= res_v_s;
        end
      end
    end
  end

  assign bus.busy     = (state_r == EXEC);
  assign bus.done     = done_r;
  assign bus.f        = f_r;
  assign bus.f_hi     = f_hi_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter W, default 8, operand/result width in bits; legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request to launch an operation; sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 MUL, 01 CMP, 10 ADD, 11 SUB.
REQ-006 x  input  W  operand A, unsigned for MUL/CMP, two's complement for overflow on ADD/SUB.
REQ-007 y  input  W  operand B, same interpretation as x.
REQ-008 busy  output  1  high while an accepted operation is executing.
REQ-009 done  output  1  one-cycle pulse marking the cycle new results are valid.
REQ-010 f  output  W  result, low half for MUL.
REQ-011 f_hi  output  W  high half of MUL product; 0 for other ops.
REQ-012 cout  output  1  carry out / compare flag.
REQ-013 overflow  output  1  signed overflow / MUL high-half-nonzero flag.

Function
REQ-014 FSM states IDLE, EXEC; busy = (state == EXEC).
REQ-015 IDLE with start=1 at edge k: op, x, y latched internally, state -> EXEC; op/x/y changes after edge k shall not affect the result.
REQ-016 start while busy=1 shall be ignored and not queued.
REQ-017 CMP/ADD/SUB: results written and done=1 at edge k+1; state -> IDLE at same edge (latency 1).
REQ-018 MUL: unsigned shift-add, one multiplier bit per cycle, LSB first; W iterations at edges k+1..k+W; results written and done=1 at edge k+W; state -> IDLE at same edge.
REQ-019 MUL: {f_hi, f} = x*y (2W-bit exact); cout=0; overflow = (f_hi != 0).
REQ-020 CMP: cout = (x > y) unsigned; f=0; f_hi=0; overflow=0.
REQ-021 ADD: {cout, f} = x + y (W+1-bit sum); overflow = (x[W-1]==y[W-1]) && (f[W-1]!=x[W-1]); f_hi=0.
REQ-022 SUB: {cout, f} = x + ~y + 1; cout=1 means no borrow; overflow = (x[W-1]!=y[W-1]) && (f[W-1]!=x[W-1]); f_hi=0.
REQ-023 f, f_hi, cout, overflow are registered and hold their last value until the next done pulse.
REQ-024 done is high for exactly one cycle per accepted operation; never high in IDLE except the cycle following completion edge.
REQ-025 start asserted in the same cycle done=1 (state already IDLE after that edge) is accepted at the following edge; back-to-back ops supported with no dead cycle beyond that.
REQ-026 Iteration counter width = ceil(log2(W+1)); no wrap shall occur within one MUL.

Reset
REQ-027 rst_n=0 forces immediately: state IDLE, busy=0, done=0, f=0, f_hi=0, cout=0, overflow=0, counter and operand registers 0.
REQ-028 Reset during EXEC aborts the operation; no done pulse is produced for it.
REQ-029 First start is accepted at the first rising edge with rst_n=1 and start=1.

Verification (W=8)
REQ-030 ADD x=8'h7F, y=8'h01 -> one cycle later done=1, f=8'h80, cout=0, overflow=1, f_hi=0.
REQ-031 SUB x=8'h00, y=8'h01 -> f=8'hFF, cout=0, overflow=0; SUB x=8'h80, y=8'h01 -> f=8'h7F, cout=1, overflow=1.
REQ-032 MUL x=200, y=200 -> busy for 8 cycles, done at edge k+8, f=8'h40, f_hi=8'h9C, overflow=1, cout=0; MUL 15*17 -> f=8'hFF, f_hi=0, overflow=0.
REQ-033 CMP x=5, y=3 -> cout=1, f=0; CMP x=3, y=3 -> cout=0.
REQ-034 MUL started, start pulsed with op=ADD at edge k+3 -> ignored, single done at k+8 with MUL result; x/y changed mid-op -> result unchanged.
REQ-035 MUL started, rst_n low at k+4 -> all outputs 0 immediately, no done; new ADD after release completes normally.
